// File: rtl/mxu_sequencer.sv
// mxu_sequencer: loads A/B bytes into mxu, configures and starts it, waits, then streams accumulators out.
// Optional MXU_SEQ_PERF_EN adds the perf_cycles busy-cycle counter output.
module mxu_sequencer #(
    parameter int SIZE        = 4,
    parameter int CYCLES      = 20,
    parameter int WAIT_CYCLES = 65,
    parameter int RD_LAT      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [7:0]  mxu_wdata,
    output logic [31:0] mxu_awaddr,
    output logic        mxu_wready,
    output logic [31:0] mxu_araddr,
    output logic        mxu_arready,
    input  logic [31:0] mxu_rdata,
    output logic        busy,
    output logic        done
`ifdef MXU_SEQ_PERF_EN
    ,
    output logic [31:0] perf_cycles
`endif
);

    localparam int NELEM  = SIZE * SIZE;
    localparam int NBYTES = 2 * NELEM;
    localparam int NW     = $clog2(NBYTES + 1);
    localparam int KW     = $clog2(NELEM + 1);
    localparam int CMAX   = (WAIT_CYCLES > RD_LAT) ? WAIT_CYCLES : RD_LAT;
    localparam int CW     = $clog2(CMAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_G, S_LOAD, S_CFG, S_CFG_G, S_START, S_START_G,
        S_WAIT, S_RD_REQ, S_RD_WAIT, S_RD_OUT, S_DONE
    } state_t;

    state_t          r_state, w_next;
    logic [NW-1:0]   r_n;
    logic [KW-1:0]   r_k;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_wdata;
    logic [31:0]     r_awaddr, r_araddr, r_mdata;
    logic            r_wready, r_arready, r_mvalid, r_busy, r_done;
    logic            w_s_hs, w_m_hs;

    // Gated by reset so every output reads 0 while reset is held.
    assign s_ready = reset && (r_state == S_IDLE || r_state == S_LOAD);
    assign w_s_hs  = s_valid && s_ready;
    assign w_m_hs  = r_mvalid && m_ready;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_LOAD: if (w_s_hs) w_next = S_LOAD_G;
            S_LOAD_G:  w_next = (r_n == NW'(NBYTES)) ? S_CFG : S_LOAD;
            S_CFG:     w_next = S_CFG_G;
            S_CFG_G:   w_next = S_START;
            S_START:   w_next = S_START_G;
            S_START_G: w_next = S_WAIT;
            S_WAIT:    if (r_cnt == CW'(WAIT_CYCLES - 1)) w_next = S_RD_REQ;
            S_RD_REQ:  w_next = S_RD_WAIT;
            S_RD_WAIT: if (r_cnt == CW'(RD_LAT - 1)) w_next = S_RD_OUT;
            S_RD_OUT:  if (w_m_hs) w_next = (r_k == KW'(NELEM - 1)) ? S_DONE : S_RD_REQ;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_n       <= '0;
            r_k       <= '0;
            r_cnt     <= '0;
            r_wdata   <= '0;
            r_awaddr  <= '0;
            r_wready  <= 1'b0;
            r_araddr  <= '0;
            r_arready <= 1'b0;
            r_mdata   <= '0;
            r_mvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless a state re-asserts them.
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_s_hs) begin
                        r_awaddr <= 32'd2 + 32'(r_n);
                        r_wdata  <= s_data;
                        r_wready <= 1'b1;
                        r_busy   <= 1'b1;
                        r_n      <= r_n + 1'b1;
                    end
                end
                S_CFG: begin
                    r_awaddr <= 32'd1;
                    r_wdata  <= 8'(CYCLES);
                    r_wready <= 1'b1;
                end
                S_START: begin
                    r_awaddr <= 32'd0;
                    r_wdata  <= 8'h01;
                    r_wready <= 1'b1;
                end
                S_START_G: begin
                    r_awaddr <= 32'd0;
                    r_cnt    <= '0;
                end
                S_WAIT: r_cnt <= r_cnt + 1'b1;
                S_RD_REQ: begin
                    r_araddr  <= 32'd1 + 32'(r_k);
                    r_arready <= 1'b1;
                    r_cnt     <= '0;
                end
                S_RD_WAIT: begin
                    if (r_cnt == CW'(RD_LAT - 1)) begin
                        r_mdata  <= mxu_rdata;
                        r_mvalid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD_OUT: begin
                    if (w_m_hs) begin
                        r_mvalid <= 1'b0;
                        r_k      <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_n    <= '0;
                    r_k    <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef MXU_SEQ_PERF_EN
    logic [31:0] r_perf;
    // Busy is still high during DONE, so skip that cycle to freeze the count there.
    always_ff @(posedge clk) begin
        if (!reset)                            r_perf <= '0;
        else if (r_state == S_IDLE && w_s_hs)  r_perf <= '0;
        else if (r_busy && r_state != S_DONE)  r_perf <= r_perf + 32'd1;
    end
    assign perf_cycles = r_perf;
`endif

    assign mxu_wdata   = r_wdata;
    assign mxu_awaddr  = r_awaddr;
    assign mxu_wready  = r_wready;
    assign mxu_araddr  = r_araddr;
    assign mxu_arready = r_arready;
    assign m_data      = r_mdata;
    assign m_valid     = r_mvalid;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
